// File: rtl/pr_stage_reg.sv
// ---------------------------------------------------------------------------
// pr_stage_reg
//   Parametrised pipeline-stage register. Carries a PC and an instruction word
//   from one stage to the next with one cycle of latency, together with a
//   valid bit. Supports hold (stall) and bubble insertion (flush) with fixed
//   priority reset > flush > stall > load, and keeps saturating stall/flush
//   event counters.
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   reset      in   synchronous active-low reset
//   stall      in   hold current contents
//   flush      in   replace contents with a bubble (overrides stall)
//   in_valid   in   upstream slot holds a real instruction
//   in_pc      in   upstream PC                      [PC_W]
//   in_instr   in   upstream instruction             [INSTR_W]
//   out_valid  out  registered valid
//   out_pc     out  registered PC                    [PC_W]
//   out_instr  out  registered instruction           [INSTR_W]
//   cnt_clr    in   synchronous clear of both counters
//   stall_cnt  out  saturating count of stalled cycles [CNT_W]
//   flush_cnt  out  saturating count of flushed cycles [CNT_W]
// ---------------------------------------------------------------------------
module pr_stage_reg #(
    parameter int unsigned               PC_W      = 32,
    parameter int unsigned               INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]        NOP_INSTR = '0,
    parameter logic [PC_W-1:0]           RESET_PC  = '0,
    parameter int unsigned               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Event qualification: a flush masks a simultaneous stall, so only one
    // of the two counters can advance in any cycle.
    logic flush_evt;
    logic stall_evt;

    always_comb begin
        flush_evt = flush;
        stall_evt = stall & ~flush;
    end

    // Datapath register
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_pc    <= RESET_PC;
            out_instr <= NOP_INSTR;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_pc    <= in_pc;
            out_instr <= NOP_INSTR;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_pc    <= in_pc;
            // An invalid slot never exposes stale instruction bits.
            out_instr <= in_valid ? in_instr : NOP_INSTR;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pr_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pr_stage_reg
//   Directed self-checking bench for pr_stage_reg (CNT_W=4 so that counter
//   saturation is reachable in a few cycles).
// ---------------------------------------------------------------------------
module tb_pr_stage_reg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 4;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               flush;
    logic               in_valid;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               cnt_clr;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    int checks;
    int errors;

    pr_stage_reg #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .NOP_INSTR(32'h0000_0000),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .cnt_clr  (cnt_clr),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h8C01_0004;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", out_instr); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d want 0", flush_cnt); end
    endtask

    task automatic test_load_stream();
        logic [31:0] pcs   [3];
        logic [31:0] instrs[3];
        pcs    = '{32'h100, 32'h104, 32'h108};
        instrs = '{32'h2001_0001, 32'h2002_0002, 32'h2003_0003};
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = pcs[i]; in_instr = instrs[i];
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL load_valid[%0d] got %h want 1", i, out_valid); end
            checks++; if (out_pc !== pcs[i]) begin errors++; $display("FAIL load_pc[%0d] got %h want %h", i, out_pc, pcs[i]); end
            checks++; if (out_instr !== instrs[i]) begin errors++; $display("FAIL load_instr[%0d] got %h want %h", i, out_instr, instrs[i]); end
        end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL load_stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL load_flush_cnt got %0d want 0", flush_cnt); end
    endtask

    task automatic test_stall_flush();
        in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'hAABB_CCDD;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h210 + 32'(4 * i); in_instr = 32'h1234_0000 + 32'(i);
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %h want 1", i, out_valid); end
            checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL stall_pc[%0d] got %h want 00000200", i, out_pc); end
            checks++; if (out_instr !== 32'hAABB_CCDD) begin errors++; $display("FAIL stall_instr[%0d] got %h want aabbccdd", i, out_instr); end
        end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_cnt3 got %0d want 3", stall_cnt); end
        checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL stall_flush_cnt got %0d want 0", flush_cnt); end
        // flush together with stall
        flush = 1'b1; in_pc = 32'h2F0; in_instr = 32'h5555_AAAA;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fos_valid got %h want 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL fos_instr got %h want 00000000", out_instr); end
        checks++; if (out_pc !== 32'h2F0) begin errors++; $display("FAIL fos_pc got %h want 000002f0", out_pc); end
        checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL fos_flush_cnt got %0d want 1", flush_cnt); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL fos_stall_cnt got %0d want 3", stall_cnt); end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_invalid_slot();
        in_valid = 1'b0; in_pc = 32'h300; in_instr = 32'hFFFF_FFFF;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inv_valid got %h want 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL inv_instr got %h want 00000000", out_instr); end
        checks++; if (out_pc !== 32'h300) begin errors++; $display("FAIL inv_pc got %h want 00000300", out_pc); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL inv_stall_cnt got %0d want 3", stall_cnt); end
        checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL inv_flush_cnt got %0d want 1", flush_cnt); end
    endtask

    task automatic test_counter_saturation();
        logic [3:0] exp_cnt;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL clr_stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL clr_flush_cnt got %0d want 0", flush_cnt); end
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL sat_stall_cnt[%0d] got %0d want %0d", i, stall_cnt, exp_cnt); end
        end
        // flush events to saturate the flush counter too
        flush = 1'b1;
        for (int i = 1; i <= 17; i++) step();
        checks++; if (flush_cnt !== 4'd15) begin errors++; $display("FAIL sat_flush_cnt got %0d want 15", flush_cnt); end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_hold got %0d want 15", stall_cnt); end
        // clear beats a simultaneous increment
        flush = 1'b0; cnt_clr = 1'b1;
        step();
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL clrinc_stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL clrinc_flush_cnt got %0d want 0", flush_cnt); end
        cnt_clr = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'h1111_2222;
        step();
        stall = 1'b1; in_pc = 32'h440; in_instr = 32'h9999_9999;
        step();
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL mid_stall_cnt got %0d want 1", stall_cnt); end
        // reset during stall, with cnt_clr also low
        reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %h want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h want 00000000", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL mid_rst_instr got %h want 00000000", out_instr); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_stall_cnt got %0d want 0", stall_cnt); end
        // first unstalled edge with reset high loads
        reset = 1'b1; stall = 1'b0; in_pc = 32'h404; in_instr = 32'h3333_4444;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %h want 1", out_valid); end
        checks++; if (out_pc !== 32'h404) begin errors++; $display("FAIL post_rst_pc got %h want 00000404", out_pc); end
        checks++; if (out_instr !== 32'h3333_4444) begin errors++; $display("FAIL post_rst_instr got %h want 33334444", out_instr); end
        // reset during flush: reset image, not the flush PC
        flush = 1'b1; reset = 1'b0; in_pc = 32'h508;
        step();
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_flush_pc got %h want 00000000", out_pc); end
        checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL rst_flush_cnt got %0d want 0", flush_cnt); end
        // reset beats cnt_clr trivially; check flush alone counts after release
        reset = 1'b1;
        step();
        checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL flush_only_cnt got %0d want 1", flush_cnt); end
        checks++; if (out_pc !== 32'h508) begin errors++; $display("FAIL flush_only_pc got %h want 00000508", out_pc); end
        flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_stream();
        test_stall_flush();
        test_invalid_slot();
        test_counter_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
